// File: rtl/comm_pkg.sv
// rtl/comm_pkg.sv - shared types and constants for the transmitter arbiter
package comm_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_SEND  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int N_REQ_DEF  = 4;
    localparam int WORD_W_DEF = 32;

    // Index width for a requester count; a single requester still needs one bit
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDX_W_DEF = idx_w(N_REQ_DEF);

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner selection
module rr_pick
    import comm_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_served,
    output logic             valid,
    output logic [IDX_W-1:0] index
);

    // Scan from last_served+1 upward with wrap; the first set bit wins
    always_comb begin
        int k;
        k     = 0;
        valid = 1'b0;
        index = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            k = int'(last_served) + i;
            if (k >= N_REQ) begin
                k = k - N_REQ;
            end
            if (!valid && req[k]) begin
                valid = 1'b1;
                index = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/comm_arbiter.sv
// rtl/comm_arbiter.sv - round-robin arbiter feeding one serial transmitter
module comm_arbiter
    import comm_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int WORD_W   = WORD_W_DEF,
    parameter int START_TO = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*WORD_W-1:0] req_word,
    output logic [N_REQ-1:0]        done,
    output logic [N_REQ-1:0]        err,
    output logic                    tx_start,
    output logic [WORD_W-1:0]       tx_word,
    input  logic                    tx_busy,
    output logic [idx_w(N_REQ)-1:0] owner,
    output logic                    active
);

    localparam int IDX_W = idx_w(N_REQ);
    localparam int CNT_W = $clog2(START_TO + 1);

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   last_served;

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_index;
    logic               grant;
    logic               timeout;

    logic               tx_start_d;
    logic [WORD_W-1:0]  tx_word_d;
    logic [N_REQ-1:0]   done_d;
    logic [N_REQ-1:0]   err_d;
    logic [IDX_W-1:0]   owner_d;
    logic               active_d;
    logic [IDX_W-1:0]   last_served_d;
    logic [CNT_W-1:0]   cnt_d;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req         (req),
        .last_served (last_served),
        .valid       (pick_valid),
        .index       (pick_index)
    );

    // A grant needs an idle transmitter so the new word never collides with a shift in progress
    assign grant   = (state == S_IDLE) && !tx_busy && pick_valid;
    // Fires on the last allowed START cycle, so tx_start stays up for exactly START_TO cycles
    assign timeout = (state == S_START) && !tx_busy && (cnt == CNT_W'(START_TO - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (grant) begin
                    next_state = S_START;
                end
            end
            S_START: begin
                if (tx_busy) begin
                    next_state = S_SEND;
                end else if (timeout) begin
                    next_state = S_IDLE;
                end
            end
            S_SEND: begin
                if (!tx_busy) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Next values for every output and bookkeeping register
    always_comb begin
        tx_word_d     = tx_word;
        owner_d       = owner;
        done_d        = '0;
        err_d         = '0;
        last_served_d = last_served;
        cnt_d         = cnt;

        if (grant) begin
            tx_word_d = req_word[pick_index*WORD_W +: WORD_W];
            owner_d   = pick_index;
            cnt_d     = '0;
        end

        if ((state == S_START) && !tx_busy && (cnt != CNT_W'(START_TO))) begin
            cnt_d = cnt + CNT_W'(1);
        end

        if (timeout) begin
            err_d[owner]  = 1'b1;
            last_served_d = owner;
        end

        if (state == S_DONE) begin
            done_d[owner] = 1'b1;
            last_served_d = owner;
        end

        tx_start_d = (next_state == S_START);
        active_d   = (next_state != S_IDLE);
    end

    // Output registers; reset also discards any pending done/err of an aborted transfer
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_start    <= 1'b0;
            tx_word     <= '0;
            done        <= '0;
            err         <= '0;
            owner       <= '0;
            active      <= 1'b0;
            last_served <= IDX_W'(N_REQ - 1);
            cnt         <= '0;
        end else begin
            tx_start    <= tx_start_d;
            tx_word     <= tx_word_d;
            done        <= done_d;
            err         <= err_d;
            owner       <= owner_d;
            active      <= active_d;
            last_served <= last_served_d;
            cnt         <= cnt_d;
        end
    end

endmodule

// File: tb/tb_comm_arbiter.sv
// tb/tb_comm_arbiter.sv - directed self-checking bench for comm_arbiter
module tb_comm_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int TO = 255;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_word;
    logic [N-1:0]   done;
    logic [N-1:0]   err;
    logic           tx_start;
    logic [W-1:0]   tx_word;
    logic           tx_busy;
    logic [1:0]     owner;
    logic           active;

    int n_chk  = 0;
    int n_fail = 0;

    comm_arbiter #(
        .N_REQ    (N),
        .WORD_W   (W),
        .START_TO (TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_word (req_word),
        .done     (done),
        .err      (err),
        .tx_start (tx_start),
        .tx_word  (tx_word),
        .tx_busy  (tx_busy),
        .owner    (owner),
        .active   (active)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  rq;
        logic        busy;
        logic        st;
        logic [31:0] wd;
        logic [3:0]  dn;
        logic [1:0]  ow;
        logic        ac;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic b,
                                input logic st, input logic [31:0] wd, input logic [3:0] dn,
                                input logic [1:0] ow, input logic ac);
        vec_t v;
        v.rst = r; v.rq = rq; v.busy = b; v.st = st;
        v.wd = wd; v.dn = dn; v.ow = ow; v.ac = ac;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        req     = '0;
        tx_busy = 1'b0;
        step();
        reset   = 1'b0;
    endtask

    int          n_st, n_err, n_done, hold, ng, nd, bad;
    logic [3:0]  err_v;
    logic        prev_st;
    int          grants[8];
    logic [3:0]  dones[8];
    int          exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        reset    = 1'b1;
        req      = '0;
        tx_busy  = 1'b0;
        req_word = {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};

        //             rst  req      busy  start word          done     own  act
        tbl.push_back(mk(1, 4'b0000, 0,   0, 32'h0,        4'b0000, 0, 0));
        tbl.push_back(mk(0, 4'b0001, 0,   1, 32'hDEADBEEF, 4'b0000, 0, 1));
        tbl.push_back(mk(0, 4'b0001, 0,   1, 32'hDEADBEEF, 4'b0000, 0, 1));
        tbl.push_back(mk(0, 4'b0001, 1,   0, 32'hDEADBEEF, 4'b0000, 0, 1));
        tbl.push_back(mk(0, 4'b0000, 1,   0, 32'hDEADBEEF, 4'b0000, 0, 1));
        tbl.push_back(mk(0, 4'b0000, 0,   0, 32'hDEADBEEF, 4'b0000, 0, 1));
        tbl.push_back(mk(0, 4'b0000, 0,   0, 32'hDEADBEEF, 4'b0001, 0, 0));
        tbl.push_back(mk(0, 4'b0110, 0,   1, 32'h11111111, 4'b0000, 1, 1));
        tbl.push_back(mk(0, 4'b0110, 1,   0, 32'h11111111, 4'b0000, 1, 1));
        tbl.push_back(mk(0, 4'b0110, 0,   0, 32'h11111111, 4'b0000, 1, 1));
        tbl.push_back(mk(0, 4'b0110, 0,   0, 32'h11111111, 4'b0010, 1, 0));
        tbl.push_back(mk(0, 4'b0110, 0,   1, 32'h22222222, 4'b0000, 2, 1));
        tbl.push_back(mk(0, 4'b0110, 1,   0, 32'h22222222, 4'b0000, 2, 1));
        tbl.push_back(mk(0, 4'b0110, 0,   0, 32'h22222222, 4'b0000, 2, 1));
        tbl.push_back(mk(0, 4'b0110, 1,   0, 32'h22222222, 4'b0100, 2, 0));
        tbl.push_back(mk(0, 4'b0110, 1,   0, 32'h22222222, 4'b0000, 2, 0));
        tbl.push_back(mk(0, 4'b0110, 1,   0, 32'h22222222, 4'b0000, 2, 0));
        tbl.push_back(mk(0, 4'b0110, 0,   1, 32'h11111111, 4'b0000, 1, 1));
        tbl.push_back(mk(1, 4'b0110, 0,   0, 32'h0,        4'b0000, 0, 0));
        tbl.push_back(mk(0, 4'b1001, 0,   1, 32'hDEADBEEF, 4'b0000, 0, 1));
        tbl.push_back(mk(0, 4'b1001, 1,   0, 32'hDEADBEEF, 4'b0000, 0, 1));
        tbl.push_back(mk(1, 4'b1001, 1,   0, 32'h0,        4'b0000, 0, 0));
        tbl.push_back(mk(0, 4'b1001, 0,   1, 32'hDEADBEEF, 4'b0000, 0, 1));

        foreach (tbl[i]) begin
            reset   = tbl[i].rst;
            req     = tbl[i].rq;
            tx_busy = tbl[i].busy;
            step();
            chk($sformatf("row%0d tx_start", i), tx_start, tbl[i].st);
            chk($sformatf("row%0d tx_word", i),  tx_word,  tbl[i].wd);
            chk($sformatf("row%0d done", i),     done,     tbl[i].dn);
            chk($sformatf("row%0d err", i),      err,      4'b0000);
            chk($sformatf("row%0d owner", i),    owner,    tbl[i].ow);
            chk($sformatf("row%0d active", i),   active,   tbl[i].ac);
        end

        // Start timeout: transmitter never acknowledges requester 2
        do_reset();
        req    = 4'b0100;
        n_st   = 0;
        n_err  = 0;
        n_done = 0;
        err_v  = '0;
        for (int c = 0; c < 400; c++) begin
            step();
            if (tx_start) n_st++;
            if (done != 0) n_done++;
            if (err != 0) begin
                n_err++;
                err_v = err;
                req   = '0;
                break;
            end
        end
        chk("timeout tx_start cycles", n_st, TO);
        chk("timeout err bit", err_v, 4'b0100);
        chk("timeout err count", n_err, 1);
        chk("timeout no done", n_done, 0);
        step();
        chk("timeout err single pulse", err, 4'b0000);
        chk("timeout back idle active", active, 1'b0);
        chk("timeout back idle tx_start", tx_start, 1'b0);
        step();
        chk("timeout no regrant", tx_start, 1'b0);

        // Single request: busy rises 3 cycles after tx_start and lasts 40 cycles
        do_reset();
        req = 4'b0001;
        step();
        chk("single grant tx_start", tx_start, 1'b1);
        chk("single grant word", tx_word, 32'hDEADBEEF);
        for (int k = 1; k <= 50; k++) begin
            tx_busy = (k >= 3 && k <= 42);
            req     = (k <= 44) ? 4'b0001 : 4'b0000;
            step();
            chk($sformatf("single k%0d tx_start", k), tx_start, (k < 3));
            chk($sformatf("single k%0d done", k), done, (k == 44) ? 4'b0001 : 4'b0000);
            chk($sformatf("single k%0d tx_word", k), tx_word, 32'hDEADBEEF);
        end

        // Contention: all four requesters held high against a responsive transmitter
        do_reset();
        req     = 4'b1111;
        hold    = 0;
        ng      = 0;
        nd      = 0;
        bad     = 0;
        prev_st = 1'b0;
        for (int c = 0; c < 600; c++) begin
            step();
            if (tx_start && !prev_st) begin
                if (ng < 8) grants[ng] = int'(owner);
                ng++;
            end
            prev_st = tx_start;
            if (done != 0) begin
                if (nd < 8) dones[nd] = done;
                nd++;
            end
            if (err != 0 || (done != 0 && !$onehot(done))) bad++;
            if (nd == 5) break;
            if (tx_start && !tx_busy) begin
                tx_busy = 1'b1;
                hold    = 4;
            end else if (tx_busy) begin
                hold--;
                if (hold == 0) tx_busy = 1'b0;
            end
        end
        tx_busy = 1'b0;
        chk("contention done count", nd, 5);
        chk("contention grant count", (ng >= 5), 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("contention grant%0d", i), grants[i], exp_order[i]);
            chk($sformatf("contention done%0d", i), dones[i], 4'b0001 << exp_order[i]);
        end
        chk("contention pulse hygiene", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
